// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit.
//   - state_t        : control FSM states
//   - OP_*           : major opcode values (instr[6:0])
//   - ALU_*          : aluControl encodings, {funct7[5], funct3}
//   - PC_*, WD_*,
//     SRCB_*         : datapath mux select encodings
//   - alu_cls_t      : operation class handed to alu_decoder
//   - branch helpers : funct3 legality and taken evaluation
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_LOAD,
    S_STORE,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LUI,
    S_AUIPC,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_ALU    = 2'b11;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_MEM   = 2'b01;
  localparam logic [1:0] WD_IMMU  = 2'b10;
  localparam logic [1:0] WD_PC4   = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMMI = 2'b01;
  localparam logic [1:0] SRCB_IMMS = 2'b10;
  localparam logic [1:0] SRCB_IMMU = 2'b11;

  localparam logic SRCA_RD1 = 1'b0;
  localparam logic SRCA_PC  = 1'b1;

  localparam logic IMM_B = 1'b0;
  localparam logic IMM_J = 1'b1;

  typedef enum logic [1:0] {
    ALU_CLS_ADD,
    ALU_CLS_SUB,
    ALU_CLS_R,
    ALU_CLS_I
  } alu_cls_t;

  // funct3 = 010/011 has no branch meaning in RV32I.
  function automatic logic branch_f3_legal(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  // Flags come from rs1 - rs2; bit 0 of funct3 inverts the base condition.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic zero,
                                        input logic lt,
                                        input logic ltu);
    logic base;
    case (f3[2:1])
      2'b00:   base = zero;
      2'b10:   base = lt;
      2'b11:   base = ltu;
      default: base = 1'b0;
    endcase
    return base ^ f3[0];
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder.
// Ports:
//   alu_cls     in  operation class chosen by the control FSM
//   funct3      in  instr[14:12]
//   funct7_b5   in  instr[30]
//   alu_control out {funct7[5], funct3} style ALU operation code
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_cls_t   alu_cls,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_cls)
      ALU_CLS_ADD: alu_control = ALU_ADD;
      ALU_CLS_SUB: alu_control = ALU_SUB;
      ALU_CLS_R:   alu_control = {funct7_b5, funct3};
      // For immediates instr[30] is part of the immediate, except for the
      // shift-right group where it selects arithmetic vs logical.
      ALU_CLS_I:   alu_control = {(funct3 == 3'b101) ? funct7_b5 : 1'b0, funct3};
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control unit for the RV32I core.
// Sequences each instruction through FETCH, DECODE and one execute/memory
// state, driving datapath selects and write enables.
//
// state  | meaning
// -------+-----------------------------------------------
// FETCH  | imemReq high until imemReady, then load IR
// DECODE | one cycle, branch on opcode
// EXEC_R | register-register ALU op, write back, retire
// EXEC_I | register-immediate ALU op, write back, retire
// LOAD   | dmemReq until dmemReady, write back read data
// STORE  | dmemReq+dmemWe until dmemReady, retire
// BRANCH | compare via SUB, pick next PC
// JAL    | rd = pc+4, pc = pc+immJ
// JALR   | rd = pc+4, pc = rs1+immI
// LUI    | rd = immU
// AUIPC  | rd = pc+immU
// TRAP   | illegal instruction, parked until reset
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   instr[31:0]                instruction register
//   zero, lt, ltu              ALU flags of the SUB result
//   imemReady, dmemReady       memory handshakes
//   imemReq, irWrite           fetch request, IR load
//   dmemReq, dmemWe            data access request, write qualifier
//   pcWrite, regWrite          PC / register-file write enables
//   pcSrc, wdSrc, aluSrcA,
//   aluSrcB, immSrc            datapath mux selects
//   aluControl[3:0]            ALU operation
//   illegal                    sticky illegal-instruction flag
module mc_control_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  input  logic        imemReady,
  input  logic        dmemReady,
  output logic        imemReq,
  output logic        irWrite,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic        pcWrite,
  output logic        regWrite,
  output logic [1:0]  pcSrc,
  output logic [1:0]  wdSrc,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic        immSrc,
  output logic [3:0]  aluControl,
  output logic        illegal
);

  state_t     state_q;
  state_t     state_d;
  alu_cls_t   alu_cls;
  logic [3:0] alu_ctl_dec;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       unused_instr_bits;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7_b5 = instr[30];
  // Register specifiers and immediates belong to the datapath.
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  alu_decoder u_alu_decoder (
    .alu_cls     (alu_cls),
    .funct3      (funct3),
    .funct7_b5   (funct7_b5),
    .alu_control (alu_ctl_dec)
  );

  always_comb begin
    state_d  = state_q;
    alu_cls  = ALU_CLS_ADD;
    imemReq  = 1'b0;
    irWrite  = 1'b0;
    dmemReq  = 1'b0;
    dmemWe   = 1'b0;
    pcWrite  = 1'b0;
    regWrite = 1'b0;
    pcSrc    = PC_PLUS4;
    wdSrc    = WD_ALU;
    aluSrcA  = SRCA_RD1;
    aluSrcB  = SRCB_RD2;
    immSrc   = IMM_B;

    case (state_q)
      S_FETCH: begin
        imemReq = 1'b1;
        if (imemReady) begin
          irWrite = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        case (opcode)
          OP_R:      state_d = S_EXEC_R;
          OP_I:      state_d = S_EXEC_I;
          OP_LOAD:   state_d = S_LOAD;
          OP_STORE:  state_d = S_STORE;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          OP_AUIPC:  state_d = S_AUIPC;
          default:   state_d = S_TRAP;
        endcase
      end

      S_EXEC_R: begin
        aluSrcB  = SRCB_RD2;
        alu_cls  = ALU_CLS_R;
        wdSrc    = WD_ALU;
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        pcSrc    = PC_PLUS4;
        state_d  = S_FETCH;
      end

      S_EXEC_I: begin
        aluSrcB  = SRCB_IMMI;
        alu_cls  = ALU_CLS_I;
        wdSrc    = WD_ALU;
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        pcSrc    = PC_PLUS4;
        state_d  = S_FETCH;
      end

      S_LOAD: begin
        aluSrcB = SRCB_IMMI;
        alu_cls = ALU_CLS_ADD;
        dmemReq = 1'b1;
        if (dmemReady) begin
          regWrite = 1'b1;
          wdSrc    = WD_MEM;
          pcWrite  = 1'b1;
          state_d  = S_FETCH;
        end
      end

      S_STORE: begin
        aluSrcB = SRCB_IMMS;
        alu_cls = ALU_CLS_ADD;
        dmemReq = 1'b1;
        dmemWe  = 1'b1;
        if (dmemReady) begin
          pcWrite = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_BRANCH: begin
        if (branch_f3_legal(funct3)) begin
          aluSrcB = SRCB_RD2;
          alu_cls = ALU_CLS_SUB;
          immSrc  = IMM_B;
          pcWrite = 1'b1;
          pcSrc   = branch_taken(funct3, zero, lt, ltu) ? PC_BRANCH : PC_PLUS4;
          state_d = S_FETCH;
        end else begin
          state_d = S_TRAP;
        end
      end

      S_JAL: begin
        immSrc   = IMM_J;
        pcSrc    = PC_BRANCH;
        wdSrc    = WD_PC4;
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        state_d  = S_FETCH;
      end

      S_JALR: begin
        aluSrcA  = SRCA_RD1;
        aluSrcB  = SRCB_IMMI;
        alu_cls  = ALU_CLS_ADD;
        pcSrc    = PC_ALU;
        wdSrc    = WD_PC4;
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        state_d  = S_FETCH;
      end

      S_LUI: begin
        wdSrc    = WD_IMMU;
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        pcSrc    = PC_PLUS4;
        state_d  = S_FETCH;
      end

      S_AUIPC: begin
        aluSrcA  = SRCA_PC;
        aluSrcB  = SRCB_IMMU;
        alu_cls  = ALU_CLS_ADD;
        wdSrc    = WD_ALU;
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        pcSrc    = PC_PLUS4;
        state_d  = S_FETCH;
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Reset silences the datapath immediately, so an in-flight memory
    // access is abandoned and no write enable can leak out.
    if (reset) begin
      alu_cls  = ALU_CLS_ADD;
      imemReq  = 1'b0;
      irWrite  = 1'b0;
      dmemReq  = 1'b0;
      dmemWe   = 1'b0;
      pcWrite  = 1'b0;
      regWrite = 1'b0;
      pcSrc    = PC_PLUS4;
      wdSrc    = WD_ALU;
      aluSrcA  = SRCA_RD1;
      aluSrcB  = SRCB_RD2;
      immSrc   = IMM_B;
    end
  end

  assign aluControl = alu_ctl_dec;
  // TRAP is only left through reset, which makes the flag sticky.
  assign illegal    = (state_q == S_TRAP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic        imemReady = 1'b0, dmemReady = 1'b0;

  logic        imemReq, irWrite, dmemReq, dmemWe, pcWrite, regWrite;
  logic [1:0]  pcSrc, wdSrc, aluSrcB;
  logic        aluSrcA, immSrc, illegal;
  logic [3:0]  aluControl;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .instr(instr),
    .zero(zero), .lt(lt), .ltu(ltu),
    .imemReady(imemReady), .dmemReady(dmemReady),
    .imemReq(imemReq), .irWrite(irWrite),
    .dmemReq(dmemReq), .dmemWe(dmemWe),
    .pcWrite(pcWrite), .regWrite(regWrite),
    .pcSrc(pcSrc), .wdSrc(wdSrc),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .immSrc(immSrc), .aluControl(aluControl),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] pc_src;
    logic [1:0] wd_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_src;
    logic [3:0] alu_ctl;
    logic       illegal;
  } out_t;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        z, l, lu;
    int          iw, dw;
    out_t        fin;
    out_t        wt;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  out_t f_ok, f_wait, idle, trap_o;

  function automatic out_t mk(input logic pcw, input logic rw,
                              input logic [1:0] pcs, input logic [1:0] wds,
                              input logic sa, input logic [1:0] sb,
                              input logic imm, input logic [3:0] ac,
                              input logic dreq, input logic dwe);
    out_t o = '0;
    o.pc_write = pcw; o.reg_write = rw; o.pc_src = pcs; o.wd_src = wds;
    o.alu_src_a = sa; o.alu_src_b = sb; o.imm_src = imm; o.alu_ctl = ac;
    o.dmem_req = dreq; o.dmem_we = dwe;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.imem_req = imemReq;   o.ir_write = irWrite;
    o.dmem_req = dmemReq;   o.dmem_we = dmemWe;
    o.pc_write = pcWrite;   o.reg_write = regWrite;
    o.pc_src = pcSrc;       o.wd_src = wdSrc;
    o.alu_src_a = aluSrcA;  o.alu_src_b = aluSrcB;
    o.imm_src = immSrc;     o.alu_ctl = aluControl;
    o.illegal = illegal;
    return o;
  endfunction

  function automatic void add_v(input string n, input logic [31:0] ins,
                                input logic z, input logic l, input logic lu,
                                input int iw, input int dw,
                                input out_t fin, input out_t wt);
    vec_t v;
    v.name = n; v.ins = ins; v.z = z; v.l = l; v.lu = lu;
    v.iw = iw; v.dw = dw; v.fin = fin; v.wt = wt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%05h want=%05h", nm, got, want);
    end
  endtask

  // One clock: queue the expectation, compare on the falling edge,
  // return just after the next rising edge with inputs free to change.
  task automatic step(input string nm, input out_t e);
    out_t g, x;
    exp_q.push_back(e);
    @(negedge clk);
    g = sample();
    x = exp_q.pop_front();
    chk(nm, {13'b0, g}, {13'b0, x});
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    instr = v.ins; zero = v.z; lt = v.l; ltu = v.lu;
    for (int i = 0; i < v.iw; i++) begin
      imemReady = 1'b0; dmemReady = 1'b1;
      step({v.name, "/fetch_wait"}, f_wait);
    end
    imemReady = 1'b1; dmemReady = 1'b0;
    step({v.name, "/fetch"}, f_ok);
    imemReady = 1'b0; dmemReady = 1'b1;
    step({v.name, "/decode"}, idle);
    imemReady = 1'b1;
    for (int i = 0; i < v.dw; i++) begin
      dmemReady = 1'b0;
      step({v.name, "/mem_wait"}, v.wt);
    end
    dmemReady = 1'b1;
    step({v.name, "/final"}, v.fin);
    imemReady = 1'b0; dmemReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t g;
    idle   = '0;
    f_ok   = '0; f_ok.imem_req = 1'b1; f_ok.ir_write = 1'b1;
    f_wait = '0; f_wait.imem_req = 1'b1;
    trap_o = '0; trap_o.illegal = 1'b1;

    add_v("add",   32'h002081B3, 0,0,0, 0,0, mk(1,1,2'b00,2'b00,0,2'b00,0,4'b0000,0,0), '0);
    add_v("sub",   32'h402081B3, 0,0,0, 0,0, mk(1,1,2'b00,2'b00,0,2'b00,0,4'b1000,0,0), '0);
    add_v("sra",   32'h4020D1B3, 0,0,0, 0,0, mk(1,1,2'b00,2'b00,0,2'b00,0,4'b1101,0,0), '0);
    add_v("addi",  32'hFFF00093, 0,0,0, 0,0, mk(1,1,2'b00,2'b00,0,2'b01,0,4'b0000,0,0), '0);
    add_v("srai",  32'h40315093, 0,0,0, 0,0, mk(1,1,2'b00,2'b00,0,2'b01,0,4'b1101,0,0), '0);
    add_v("slti",  32'h00512093, 0,0,0, 0,0, mk(1,1,2'b00,2'b00,0,2'b01,0,4'b0010,0,0), '0);
    add_v("lw_w4", 32'h0000A283, 0,0,0, 0,4, mk(1,1,2'b00,2'b01,0,2'b01,0,4'b0000,1,0),
                                             mk(0,0,2'b00,2'b00,0,2'b01,0,4'b0000,1,0));
    add_v("lw_w0", 32'h0000A283, 0,0,0, 0,0, mk(1,1,2'b00,2'b01,0,2'b01,0,4'b0000,1,0), '0);
    add_v("sw_w2", 32'h0050A023, 0,0,0, 0,2, mk(1,0,2'b00,2'b00,0,2'b10,0,4'b0000,1,1),
                                             mk(0,0,2'b00,2'b00,0,2'b10,0,4'b0000,1,1));
    add_v("beq_t", 32'h00208063, 1,0,0, 0,0, mk(1,0,2'b01,2'b00,0,2'b00,0,4'b1000,0,0), '0);
    add_v("beq_n", 32'h00208063, 0,1,1, 0,0, mk(1,0,2'b00,2'b00,0,2'b00,0,4'b1000,0,0), '0);
    add_v("bne_n", 32'h00209063, 1,0,0, 0,0, mk(1,0,2'b00,2'b00,0,2'b00,0,4'b1000,0,0), '0);
    add_v("bne_t", 32'h00209063, 0,0,0, 0,0, mk(1,0,2'b01,2'b00,0,2'b00,0,4'b1000,0,0), '0);
    add_v("blt_t", 32'h0020C063, 0,1,0, 0,0, mk(1,0,2'b01,2'b00,0,2'b00,0,4'b1000,0,0), '0);
    add_v("bge_n", 32'h0020D063, 0,1,0, 0,0, mk(1,0,2'b00,2'b00,0,2'b00,0,4'b1000,0,0), '0);
    add_v("bge_t", 32'h0020D063, 0,0,1, 0,0, mk(1,0,2'b01,2'b00,0,2'b00,0,4'b1000,0,0), '0);
    add_v("bltu_t",32'h0020E063, 0,0,1, 0,0, mk(1,0,2'b01,2'b00,0,2'b00,0,4'b1000,0,0), '0);
    add_v("bgeu_t",32'h0020F063, 0,1,0, 0,0, mk(1,0,2'b01,2'b00,0,2'b00,0,4'b1000,0,0), '0);
    add_v("bgeu_n",32'h0020F063, 0,0,1, 0,0, mk(1,0,2'b00,2'b00,0,2'b00,0,4'b1000,0,0), '0);
    add_v("jal",   32'h0080006F, 0,0,0, 0,0, mk(1,1,2'b01,2'b11,0,2'b00,1,4'b0000,0,0), '0);
    add_v("jalr",  32'h000100E7, 0,0,0, 0,0, mk(1,1,2'b11,2'b11,0,2'b01,0,4'b0000,0,0), '0);
    add_v("lui",   32'h123450B7, 0,0,0, 0,0, mk(1,1,2'b00,2'b10,0,2'b00,0,4'b0000,0,0), '0);
    add_v("auipc", 32'h12345097, 0,0,0, 0,0, mk(1,1,2'b00,2'b00,1,2'b11,0,4'b0000,0,0), '0);
    add_v("add_iw2",32'h002081B3,0,0,0, 2,0, mk(1,1,2'b00,2'b00,0,2'b00,0,4'b0000,0,0), '0);

    // Reset: everything low while reset is held.
    reset = 1'b1; imemReady = 1'b1; dmemReady = 1'b1;
    @(posedge clk); #1;
    step("reset_hold", idle);
    reset = 1'b0; imemReady = 1'b0; dmemReady = 1'b0;

    foreach (vecs[k]) run_vec(vecs[k]);

    // Reset during a store wait abandons the access without retiring it.
    instr = 32'h0050A023;
    imemReady = 1'b1; step("sw_abort/fetch", f_ok);
    imemReady = 1'b0; dmemReady = 1'b1; step("sw_abort/decode", idle);
    dmemReady = 1'b0;
    step("sw_abort/wait1", mk(0,0,2'b00,2'b00,0,2'b10,0,4'b0000,1,1));
    step("sw_abort/wait2", mk(0,0,2'b00,2'b00,0,2'b10,0,4'b0000,1,1));
    reset = 1'b1;
    @(posedge clk); #1;
    dmemReady = 1'b1;
    step("sw_abort/after_reset", idle);
    reset = 1'b0; dmemReady = 1'b0; imemReady = 1'b0;
    step("sw_abort/refetch", f_wait);

    // Branch with funct3 = 010 traps without retiring.
    instr = 32'h0020A063; zero = 1'b1;
    imemReady = 1'b1; step("bad_br/fetch", f_ok);
    imemReady = 1'b0; step("bad_br/decode", idle);
    @(negedge clk);
    g = sample();
    chk("bad_br/pcWrite", {31'b0, g.pc_write}, 32'd0);
    chk("bad_br/regWrite", {31'b0, g.reg_write}, 32'd0);
    @(posedge clk); #1;
    imemReady = 1'b1;
    step("bad_br/trap", trap_o);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; imemReady = 1'b0;
    step("bad_br/refetch", f_wait);

    // Unknown opcode traps; flag sticks and fetching stops until reset.
    instr = 32'h0000007F; zero = 1'b0;
    imemReady = 1'b1; step("trap/fetch", f_ok);
    imemReady = 1'b0; step("trap/decode", idle);
    imemReady = 1'b1; dmemReady = 1'b1;
    for (int i = 0; i < 3; i++) step("trap/hold", trap_o);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; imemReady = 1'b0; dmemReady = 1'b0;
    step("trap/cleared", f_wait);
    instr = 32'h002081B3;
    imemReady = 1'b1; step("trap/resume_fetch", f_ok);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
